cpu6_bus_responder: RTL and testbench

Bus-side counterpart of the CPU6 core: answers the core's address/data/write-enable bus with a RAM region and a memory-mapped MUX serial port. It sits between the CPU6 bus pins and the board-level serial line. It returns read data combinationally in the same cycle the address is presented, and performs writes on the clock edge where write enable is high. Outbound bytes are buffered in a small FIFO and shifted out 8N1; inbound bytes are deserialized into a status/data register pair.

---
 rtl/cpu6_bus_pkg.sv | 10 +
 rtl/cpu6_bus_responder_if.sv | 9 +
 rtl/mux_serial_tx.sv | 85 ++++++++
 rtl/cpu6_bus_responder.sv | 109 ++++++++++
 tb/tb_cpu6_bus_responder.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu6_bus_pkg.sv
// cpu6_bus_pkg: shared constants and serial state encodings for the CPU6 bus responder
package cpu6_bus_pkg;
    localparam logic [15:0] MUX_BASE_DEFAULT = 16'hF200;
    localparam int STAT_RX_READY    = 0;
    localparam int STAT_TX_NOT_FULL = 1;
    localparam int STAT_FRAMING_ERR = 2;
    localparam int STAT_OVERRUN     = 3;
    localparam int STAT_TX_IDLE     = 4;
    typedef enum logic [1:0] {SER_IDLE, SER_START, SER_DATA, SER_STOP} ser_state_t;
endpackage

// File: rtl/cpu6_bus_responder_if.sv
// cpu6_bus_responder_if: CPU6 address/data/write-enable bus
interface cpu6_bus_responder_if;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    modport master (output address, write_en, write_data, input read_data);
    modport slave (input address, write_en, write_data, output read_data);
endinterface

// File: rtl/mux_serial_tx.sv
// mux_serial_tx: TX FIFO feeding an 8N1 shifter with registered txd
module mux_serial_tx import cpu6_bus_pkg::*; #(
    parameter int BAUD_DIV   = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] data,
    output logic       full,
    output logic       empty,
    output logic       idle,
    output logic       txd
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BAUD_DIV);
    logic [7:0] fifo [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    ser_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shift, shift_n;
    logic pop, accept, bit_end, txd_n;
    assign full = count == (AW+1)'(FIFO_DEPTH);
    assign empty = count == '0;
    assign idle = state == SER_IDLE;
    // a pop in the same cycle frees a slot, so a push into a full FIFO still lands
    assign accept = push && (!full || pop);
    assign bit_end = cnt == CW'(BAUD_DIV - 1);
    always_comb begin
        state_n = state;
        cnt_n = bit_end ? '0 : cnt + CW'(1);
        bit_n = bit_idx;
        shift_n = shift;
        pop = 1'b0;
        case (state)
            SER_IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    state_n = SER_START;
                    pop = 1'b1;
                    shift_n = fifo[rd_ptr];
                end
            end
            SER_START: if (bit_end) begin
                state_n = SER_DATA;
                bit_n = '0;
            end
            SER_DATA: if (bit_end) begin
                shift_n = shift >> 1;
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) state_n = SER_STOP;
            end
            default: if (bit_end) begin
                state_n = empty ? SER_IDLE : SER_START;
                pop = !empty;
                if (!empty) shift_n = fifo[rd_ptr];
            end
        endcase
        txd_n = state_n == SER_START ? 1'b0 : state_n == SER_DATA ? shift_n[0] : 1'b1;
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state <= SER_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            txd <= 1'b1;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            shift <= shift_n;
            txd <= txd_n;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(accept) - (AW+1)'(pop);
        end
    always_ff @(posedge clock)
        if (accept) fifo[wr_ptr] <= data;
endmodule

// File: rtl/cpu6_bus_responder.sv
// cpu6_bus_responder: RAM plus memory-mapped MUX serial port answering the CPU6 bus
module cpu6_bus_responder import cpu6_bus_pkg::*; #(
    parameter int          RAM_WORDS  = 4096,
    parameter logic [15:0] MUX_BASE   = MUX_BASE_DEFAULT,
    parameter int          BAUD_DIV   = 16,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    cpu6_bus_responder_if.slave  bus,
    input  logic                 rxd,
    output logic                 txd
);
    localparam int RA = $clog2(RAM_WORDS);
    localparam int CW = $clog2(BAUD_DIV);
    logic [7:0] ram [RAM_WORDS];
    logic is_ram, is_stat, is_data, clear;
    logic tx_full, tx_empty, tx_shift_idle;
    logic rx_s1, rx_s2, rx_s3;
    ser_state_t rx_state, rx_state_n;
    logic [CW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n, rx_data, status;
    logic rx_done, rx_ready, framing_err, overrun;
    assign is_ram = bus.address < 16'(RAM_WORDS);
    assign is_stat = bus.address == MUX_BASE;
    assign is_data = bus.address == MUX_BASE + 16'd1;
    assign clear = bus.write_en && is_stat;
    always_comb begin
        status = '0;
        status[STAT_RX_READY] = rx_ready;
        status[STAT_TX_NOT_FULL] = !tx_full;
        status[STAT_FRAMING_ERR] = framing_err;
        status[STAT_OVERRUN] = overrun;
        status[STAT_TX_IDLE] = tx_empty && tx_shift_idle;
    end
    assign bus.read_data = is_ram ? ram[bus.address[RA-1:0]] : is_stat ? status : is_data ? rx_data : 8'h00;
    always_ff @(posedge clock)
        if (bus.write_en && is_ram) ram[bus.address[RA-1:0]] <= bus.write_data;
    mux_serial_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) tx (
        .clock(clock),
        .reset(reset),
        .push(bus.write_en && is_data),
        .data(bus.write_data),
        .full(tx_full),
        .empty(tx_empty),
        .idle(tx_shift_idle),
        .txd(txd)
    );
    // start is re-checked at mid-bit, then every later sample lands mid-bit too
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n = rx_cnt + CW'(1);
        rx_bit_n = rx_bit;
        rx_shift_n = rx_shift;
        rx_done = 1'b0;
        case (rx_state)
            SER_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_s2 && rx_s3) rx_state_n = SER_START;
            end
            SER_START: if (rx_cnt == CW'(BAUD_DIV / 2 - 1)) begin
                rx_cnt_n = '0;
                rx_bit_n = '0;
                rx_state_n = rx_s2 ? SER_IDLE : SER_DATA;
            end
            SER_DATA: if (rx_cnt == CW'(BAUD_DIV - 1)) begin
                rx_cnt_n = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_bit_n = rx_bit + 3'd1;
                if (rx_bit == 3'd7) rx_state_n = SER_STOP;
            end
            default: if (rx_cnt == CW'(BAUD_DIV - 1)) begin
                rx_cnt_n = '0;
                rx_done = 1'b1;
                rx_state_n = SER_IDLE;
            end
        endcase
    end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            {rx_s3, rx_s2, rx_s1} <= 3'b111;
            rx_state <= SER_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_shift <= '0;
            rx_data <= '0;
            rx_ready <= 1'b0;
            framing_err <= 1'b0;
            overrun <= 1'b0;
        end else begin
            {rx_s3, rx_s2, rx_s1} <= {rx_s2, rx_s1, rxd};
            rx_state <= rx_state_n;
            rx_cnt <= rx_cnt_n;
            rx_bit <= rx_bit_n;
            rx_shift <= rx_shift_n;
            // completion beats a same-cycle clear; the errors then describe only the new byte
            if (rx_done) begin
                rx_data <= rx_shift;
                rx_ready <= 1'b1;
                framing_err <= (framing_err && !clear) || !rx_s2;
                overrun <= (overrun || rx_ready) && !clear;
            end else if (clear) begin
                rx_ready <= 1'b0;
                framing_err <= 1'b0;
                overrun <= 1'b0;
            end
        end
endmodule

// File: tb/tb_cpu6_bus_responder.sv
// tb_cpu6_bus_responder: directed vector table plus serial frame sequences for the bus responder
module tb_cpu6_bus_responder;
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;
    logic clock = 1'b0, reset = 1'b1, rxd = 1'b1;
    logic txd;
    int applied = 0, miscompares = 0, cyc = 0, t0 = 0;
    vec_t vecs [16];
    logic [7:0] tx_bytes [5];
    logic [9:0] exp_f, got;
    logic quiet;
    cpu6_bus_responder_if bus();
    cpu6_bus_responder dut (.clock(clock), .reset(reset), .bus(bus), .rxd(rxd), .txd(txd));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask
    task automatic wait_to(input int m);
        while (cyc < t0 + m) @(negedge clock);
    endtask
    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string n);
        @(negedge clock);
        bus.address = a;
        bus.write_en = 1'b0;
        #1;
        check(n, bus.read_data, e);
    endtask
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        bus.address = a;
        bus.write_en = 1'b1;
        bus.write_data = d;
        @(negedge clock);
        bus.write_en = 1'b0;
    endtask
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            rxd = f[k];
            repeat (15) @(negedge clock);
        end
        @(negedge clock);
        rxd = 1'b1;
    endtask
    initial begin
        vecs = '{
            '{16'h0123, 1'b1, 8'hA5, 1'b0, 8'h00},
            '{16'h0123, 1'b0, 8'h00, 1'b1, 8'hA5},
            '{16'hE000, 1'b0, 8'h00, 1'b1, 8'h00},
            '{16'hE000, 1'b1, 8'hFF, 1'b0, 8'h00},
            '{16'hE000, 1'b0, 8'h00, 1'b1, 8'h00},
            '{16'h0000, 1'b1, 8'h11, 1'b0, 8'h00},
            '{16'h0FFF, 1'b1, 8'h22, 1'b0, 8'h00},
            '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h11},
            '{16'h0FFF, 1'b0, 8'h00, 1'b1, 8'h22},
            '{16'h1000, 1'b1, 8'h33, 1'b0, 8'h00},
            '{16'h1000, 1'b0, 8'h00, 1'b1, 8'h00},
            '{16'h0000, 1'b0, 8'h00, 1'b1, 8'h11},
            '{16'hF200, 1'b0, 8'h00, 1'b1, 8'h12},
            '{16'hF201, 1'b0, 8'h00, 1'b1, 8'h00},
            '{16'hF1FF, 1'b0, 8'h00, 1'b1, 8'h00},
            '{16'hF202, 1'b0, 8'h00, 1'b1, 8'h00}
        };
        tx_bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
        bus.address = 16'h0000;
        bus.write_en = 1'b0;
        bus.write_data = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_txd", {7'd0, txd}, 8'h01);
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            bus.address = vecs[i].addr;
            bus.write_en = vecs[i].we;
            bus.write_data = vecs[i].wdata;
            #1;
            if (vecs[i].chk) check($sformatf("vec%0d", i), bus.read_data, vecs[i].exp);
        end
        @(negedge clock);
        bus.write_en = 1'b0;
        // single frame 0x41, every clock of every bit
        @(negedge clock);
        bus.address = 16'hF201;
        bus.write_en = 1'b1;
        bus.write_data = 8'h41;
        @(negedge clock);
        bus.write_en = 1'b0;
        bus.address = 16'hF200;
        t0 = cyc;
        check("tx_pre", {7'd0, txd}, 8'h01);
        exp_f = {1'b1, 8'h41, 1'b0};
        for (int k = 0; k < 10; k++)
            for (int c = 0; c < 16; c++) begin
                wait_to(1 + 16 * k + c);
                check($sformatf("tx_b%0d_c%0d", k, c), {7'd0, txd}, {7'd0, exp_f[k]});
            end
        check("tx_busy_stop", bus.read_data & 8'h10, 8'h00);
        wait_to(161);
        check("tx_idle_after", bus.read_data, 8'h12);
        // five back-to-back pushes fill shifter plus FIFO; the sixth is dropped
        @(negedge clock);
        bus.address = 16'hF201;
        bus.write_en = 1'b1;
        bus.write_data = tx_bytes[0];
        @(negedge clock);
        t0 = cyc;
        for (int i = 1; i < 5; i++) begin
            bus.write_data = tx_bytes[i];
            @(negedge clock);
        end
        bus.write_en = 1'b0;
        bus.address = 16'hF200;
        #1;
        check("fifo_full", bus.read_data, 8'h00);
        @(negedge clock);
        bus.address = 16'hF201;
        bus.write_en = 1'b1;
        bus.write_data = 8'h65;
        @(negedge clock);
        bus.write_en = 1'b0;
        bus.address = 16'hF200;
        #1;
        check("fifo_drop", bus.read_data, 8'h00);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 10; k++) begin
                wait_to(1 + 160 * i + 16 * k + 8);
                got[k] = txd;
            end
            check($sformatf("frame%0d_start", i), {7'd0, got[0]}, 8'h00);
            check($sformatf("frame%0d_byte", i), got[8:1], tx_bytes[i]);
            check($sformatf("frame%0d_stop", i), {7'd0, got[9]}, 8'h01);
        end
        wait_to(801);
        check("fifo_drained", bus.read_data, 8'h12);
        quiet = 1'b1;
        for (int m = 801; m < 1000; m++) begin
            wait_to(m);
            if (txd !== 1'b1) quiet = 1'b0;
        end
        check("no_sixth_frame", {7'd0, quiet}, 8'h01);
        // receive path
        send_rx(8'h3C, 1'b1);
        rd(16'hF200, 8'h13, "rx_stat");
        rd(16'hF201, 8'h3C, "rx_data");
        send_rx(8'hC3, 1'b1);
        rd(16'hF200, 8'h1B, "ovr_stat");
        rd(16'hF201, 8'hC3, "ovr_data");
        wr(16'hF200, 8'hFF);
        rd(16'hF200, 8'h12, "clr_stat");
        send_rx(8'h5A, 1'b0);
        rd(16'hF200, 8'h17, "ferr_stat");
        rd(16'hF201, 8'h5A, "ferr_data");
        wr(16'hF200, 8'h00);
        rd(16'hF200, 8'h12, "ferr_clr");
        @(negedge clock);
        rxd = 1'b0;
        repeat (3) @(negedge clock);
        rxd = 1'b1;
        repeat (200) @(negedge clock);
        rd(16'hF200, 8'h12, "glitch_stat");
        rd(16'hF201, 8'h5A, "glitch_data");
        // reset in the middle of a transmit with a byte received and pending
        send_rx(8'h77, 1'b1);
        rd(16'hF200, 8'h13, "pre_rst_stat");
        wr(16'hF201, 8'h00);
        wr(16'hF201, 8'h00);
        repeat (50) @(negedge clock);
        check("tx_active", {7'd0, txd}, 8'h00);
        bus.address = 16'hF200;
        #2 reset = 1'b1;
        #1;
        check("rst_txd_async", {7'd0, txd}, 8'h01);
        check("rst_stat_async", bus.read_data, 8'h12);
        @(negedge clock);
        reset = 1'b0;
        rd(16'hF200, 8'h12, "rst_stat");
        rd(16'hF201, 8'h00, "rst_data");
        rd(16'h0123, 8'hA5, "rst_ram");
        quiet = 1'b1;
        for (int m = 0; m < 200; m++) begin
            @(negedge clock);
            if (txd !== 1'b1) quiet = 1'b0;
        end
        check("rst_fifo_empty", {7'd0, quiet}, 8'h01);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
